// File: rtl/seven_seg_driver.sv
// Two-digit multiplexed seven-segment driver: latches a tens/units pair and
// time-slices it onto one segment bus with an optional dark gap per slot.
module seven_seg_driver #(
  parameter int unsigned REFRESH_CYCLES     = 1200,
  parameter int unsigned BLANK_CYCLES       = 24,
  parameter bit          SEG_ACTIVE_HIGH    = 1'b1,
  parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  localparam int unsigned CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST   = CW'(REFRESH_CYCLES - 1);
  localparam int unsigned SHOW_LEN = REFRESH_CYCLES - BLANK_CYCLES;
  localparam bit HAS_GAP           = (BLANK_CYCLES != 0);
  localparam logic [6:0] DARK      = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;

  typedef enum logic [1:0] {
    SHOW_UNITS,
    GAP_UNITS,
    SHOW_TENS,
    GAP_TENS
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic [3:0]    tens_q;
  logic [3:0]    units_q;
  logic          wrap;
  logic          next_in_gap;
  logic [6:0]    seg_next;
  logic          digit_next;

  function automatic logic [6:0] decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    return pattern;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else if (load) begin
      tens_q  <= ten_count;
      units_q <= unit_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SHOW_UNITS;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  always_comb begin
    wrap        = (count == LAST);
    next_count  = wrap ? '0 : count + 1'b1;
    next_in_gap = HAS_GAP && !wrap && ((32'(count) + 32'd1) >= SHOW_LEN);
    next_state  = state;
    case (state)
      SHOW_UNITS: begin
        if (wrap)             next_state = SHOW_TENS;
        else if (next_in_gap) next_state = GAP_UNITS;
      end
      GAP_UNITS: if (wrap) next_state = SHOW_TENS;
      SHOW_TENS: begin
        if (wrap)             next_state = SHOW_UNITS;
        else if (next_in_gap) next_state = GAP_TENS;
      end
      GAP_TENS:  if (wrap) next_state = SHOW_UNITS;
      default:   next_state = SHOW_UNITS;
    endcase
  end

  // Outputs register the current slot, so a value latched on the wrap edge
  // is already in place for the first cycle of the new slot.
  always_comb begin
    digit_next = (state == SHOW_TENS) || (state == GAP_TENS);
    seg_next   = decode(digit_next ? tens_q : units_q);
    if ((state == GAP_UNITS) || (state == GAP_TENS)) begin
      seg_next = 7'h00;
    end else if (digit_next && BLANK_LEADING_ZERO && (tens_q == 4'd0)) begin
      seg_next = 7'h00;
    end
    if (!SEG_ACTIVE_HIGH) begin
      seg_next = ~seg_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments <= DARK;
      digit    <= 1'b0;
    end else begin
      segments <= seg_next;
      digit    <= digit_next;
    end
  end

endmodule

// File: doc/seven_seg_driver.md
SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 1200, clk cycles per digit slot (100 us at 12 MHz); legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 24, anti-ghost dark cycles at the end of each slot; legal range 0..REFRESH_CYCLES-1.
REQ-003 SHALL have parameter SEG_ACTIVE_HIGH, default 1, where 1 means a lit segment drives 1 and 0 means all segment outputs are inverted.
REQ-004 SHALL have parameter BLANK_LEADING_ZERO, default 1, where 1 means a tens value of 0 is displayed dark.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port load, input, 1 bit, capture strobe for ten_count/unit_count.
REQ-008 SHALL have port ten_count, input, 4 bits, tens value (0-9 valid).
REQ-009 SHALL have port unit_count, input, 4 bits, units value (0-9 valid).
REQ-010 SHALL have port segments, output, 7 bits, registered, bit0=a ... bit6=g.
REQ-011 SHALL have port digit, output, 1 bit, registered, 0 = units digit enabled, 1 = tens digit enabled.

Function
REQ-012 SHALL hold latched tens/units registers, loaded from ten_count/unit_count on every edge where load=1; held otherwise; load held high recaptures every cycle.
REQ-013 SHALL keep a slot counter 0..REFRESH_CYCLES-1, incrementing every cycle and wrapping to 0.
REQ-014 SHALL implement FSM states SHOW_UNITS, GAP_UNITS, SHOW_TENS, GAP_TENS.
REQ-015 SHALL stay in SHOW_x while counter < REFRESH_CYCLES-BLANK_CYCLES and be in GAP_x for the remaining counter values.
REQ-016 SHALL go from GAP_UNITS to SHOW_TENS and from GAP_TENS to SHOW_UNITS when the counter wraps, toggling digit on that same edge.
REQ-017 SHALL skip the GAP states when BLANK_CYCLES=0, so the SHOW_x states transition directly on wrap.
REQ-018 SHALL register digit and segments on the same edge, so the segments output never shows one digit's pattern while the other digit is enabled.
REQ-019 SHALL drive segments dark (all segments unlit) in the GAP states.
REQ-020 SHALL decode, active-high, 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F.
REQ-021 SHALL show dash 0x40 for input values 10-15, on either digit.
REQ-022 SHALL show the tens digit dark when BLANK_LEADING_ZERO=1 and latched tens=0; the units digit is never leading-zero blanked.
REQ-023 SHALL apply the SEG_ACTIVE_HIGH=0 inversion to all 7 bits after decode and blanking; "dark" is then 0x7F.
REQ-024 SHALL show a load captured on edge N in segments from edge N+1 when the slot is lit, with no wait for a slot boundary.
REQ-025 SHALL have the new value take effect when a load coincides with a slot wrap, with no old-value glitch.
REQ-026 SHALL NOT let load alter the slot counter, state, or digit.

Reset
REQ-027 SHALL, on reset_n=0 and asynchronously, set latched tens=0, units=0, counter=0, state=SHOW_UNITS, digit=0, segments=dark.
REQ-028 SHALL, on the first edge after reset_n rises, register segments = units '0' (0x3F active-high) with digit=0.
REQ-029 SHALL make reset mid-slot or mid-gap restart at SHOW_UNITS counter 0 and discard the latched values.
REQ-030 SHALL ignore load while reset_n=0.

Verification
REQ-031 Bench SHALL cover: REFRESH_CYCLES=8, BLANK_CYCLES=2, load 4/7 -> digit=0 segments=0x07 for 6 cycles, dark 2 cycles, then digit=1 segments=0x66 for 6 cycles, dark 2 cycles, repeating.
REQ-032 Bench SHALL cover: tens=0, units=5, BLANK_LEADING_ZERO=1 -> tens slot dark, units slot 0x6D; with BLANK_LEADING_ZERO=0 -> tens slot 0x3F.
REQ-033 Bench SHALL cover: ten_count=12, unit_count=15 -> both slots 0x40; SEG_ACTIVE_HIGH=0 -> 0x3F lit, GAP states 0x7F.
REQ-034 Bench SHALL cover: load pulse 9/9 mid SHOW_UNITS (counter=3) -> segments 0x6F on the next edge, slot boundary unchanged; load on a wrap edge -> new tens shown in the first tens cycle.
REQ-035 Bench SHALL cover: reset_n low for one cycle at counter=5 of SHOW_TENS -> segments dark and digit=0 immediately (asynchronously), then units '0' in SHOW_UNITS from counter 0.
REQ-036 Bench SHALL cover: BLANK_CYCLES=0 -> no dark cycles, digit toggles every 8 cycles, and a checker confirms digit and segments change on the same edge throughout.
